// File: rtl/cr_pkg.sv
// Shared constants, state encodings and state-class helpers for the CALL/RET/RETI sequencer.
package cr_pkg;

    localparam int WORD_W = 16;
    localparam int PC_W   = 2 * WORD_W;
    localparam int SP_W   = 20;

    localparam logic [SP_W-1:0] SP_INIT    = 20'hFFFFF;
    localparam logic [PC_W-1:0] INT_VECTOR = 32'h0000_0020;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_PUSH_F  = 4'd1;
    localparam state_t S_PUSH_HI = 4'd2;
    localparam state_t S_PUSH_LO = 4'd3;
    localparam state_t S_POP_LO  = 4'd4;
    localparam state_t S_POP_HI  = 4'd5;
    localparam state_t S_POP_F   = 4'd6;
    localparam state_t S_CAP     = 4'd7;
    localparam state_t S_REDIR   = 4'd8;

    // Destination of the word that arrives one cycle after a pop grant.
    typedef enum logic [1:0] {RD_LO, RD_HI, RD_FLAGS} rd_dst_t;

    function automatic logic is_push_st(state_t s);
        return (s == S_PUSH_F) || (s == S_PUSH_HI) || (s == S_PUSH_LO);
    endfunction

    function automatic logic is_pop_st(state_t s);
        return (s == S_POP_LO) || (s == S_POP_HI) || (s == S_POP_F);
    endfunction

endpackage

// File: rtl/call_ret_sequencer_if.sv
// Data-memory port shared between the sequencer (master) and the memory arbiter (slave).
interface call_ret_sequencer_if;
    import cr_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [SP_W-1:0]   mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic [WORD_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_gnt, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_gnt, mem_rdata);
endinterface

// File: rtl/stack_ptr_unit.sv
// Stack pointer register: post-decrement on push, pre-increment on pop, modulo 2^SP_W,
// with a sticky error flag for push at 0 or pop at SP_INIT.
module stack_ptr_unit
    import cr_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [SP_W-1:0] sp,
    output logic [SP_W-1:0] sp_plus1,
    output logic            err
);

    logic [SP_W-1:0] sp_d, sp_q;
    logic            err_d, err_q;

    always_comb begin
        sp_d  = sp_q;
        err_d = err_q;
        if (inc) begin
            sp_d = sp_q + SP_W'(1);
            if (sp_q == SP_INIT) err_d = 1'b1;
        end else if (dec) begin
            sp_d = sp_q - SP_W'(1);
            if (sp_q == '0) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= SP_INIT;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign sp       = sp_q;
    assign sp_plus1 = sp_q + SP_W'(1);
    assign err      = err_q;

endmodule

// File: rtl/call_ret_sequencer.sv
// CALL/RET/RETI stack sequencer; interrupt entry is built only when CALLRET_INTR_EN is defined.
module call_ret_sequencer
    import cr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call_req,
    input  logic                  ret_req,
    input  logic                  reti_req,
    input  logic [PC_W-1:0]       call_target,
    input  logic [PC_W-1:0]       ret_pc,
    input  logic [WORD_W-1:0]     flags_in,
    input  logic                  intr_req,
    call_ret_sequencer_if.master  mem,
    output logic                  stall,
    output logic                  pc_load,
    output logic [PC_W-1:0]       pc_next,
    output logic                  flags_load,
    output logic [WORD_W-1:0]     flags_out,
    output logic                  intr_ack,
    output logic [SP_W-1:0]       sp,
    output logic                  stack_err
);

    state_t            state_d, state_q;
    logic [PC_W-1:0]   tgt_d, tgt_q;
    logic [PC_W-1:0]   ret_d, ret_q;
    logic [WORD_W-1:0] flags_d, flags_q;
    logic              reti_d, reti_q;
    logic              rd_pend_d, rd_pend_q;
    rd_dst_t           rd_dst_d, rd_dst_q;

    logic              intr_go, idle, accept, is_push, is_pop, gnt_push, gnt_pop;
    logic [SP_W-1:0]   sp_plus1;

`ifdef CALLRET_INTR_EN
    assign intr_go = intr_req;
`else
    logic unused_intr;
    assign unused_intr = intr_req;
    assign intr_go     = 1'b0;
`endif

    assign idle     = (state_q == S_IDLE);
    assign accept   = idle && !rst && (intr_go || call_req || ret_req || reti_req);
    assign stall    = !idle || accept;
    assign is_push  = is_push_st(state_q);
    assign is_pop   = is_pop_st(state_q);
    assign gnt_push = is_push && mem.mem_gnt && !rst;
    assign gnt_pop  = is_pop && mem.mem_gnt && !rst;

    stack_ptr_unit u_sp (
        .clk      (clk),
        .rst      (rst),
        .inc      (gnt_pop),
        .dec      (gnt_push),
        .sp       (sp),
        .sp_plus1 (sp_plus1),
        .err      (stack_err)
    );

    // Memory outputs depend only on state and sp, so they hold steady while waiting for a grant.
    assign mem.mem_req  = (is_push || is_pop) && !rst;
    assign mem.mem_we   = is_push;
    assign mem.mem_addr = is_pop ? sp_plus1 : (is_push ? sp : '0);

    always_comb begin
        case (state_q)
            S_PUSH_F:  mem.mem_wdata = flags_q;
            S_PUSH_HI: mem.mem_wdata = ret_q[PC_W-1:WORD_W];
            S_PUSH_LO: mem.mem_wdata = ret_q[WORD_W-1:0];
            default:   mem.mem_wdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        ret_d     = ret_q;
        flags_d   = flags_q;
        reti_d    = reti_q;
        rd_dst_d  = rd_dst_q;
        rd_pend_d = gnt_pop;

        if (rd_pend_q) begin
            case (rd_dst_q)
                RD_LO:   tgt_d[WORD_W-1:0]    = mem.mem_rdata;
                RD_HI:   tgt_d[PC_W-1:WORD_W] = mem.mem_rdata;
                default: flags_d              = mem.mem_rdata;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ret_d   = ret_pc;
                    flags_d = flags_in;
                    tgt_d   = call_target;
                    reti_d  = 1'b0;
                    if (intr_go) begin
                        tgt_d   = INT_VECTOR;
                        state_d = S_PUSH_F;
                    end else if (call_req) begin
                        state_d = S_PUSH_HI;
                    end else begin
                        reti_d  = !ret_req;
                        state_d = S_POP_LO;
                    end
                end
            end
            S_PUSH_F:  if (mem.mem_gnt) state_d = S_PUSH_HI;
            S_PUSH_HI: if (mem.mem_gnt) state_d = S_PUSH_LO;
            S_PUSH_LO: if (mem.mem_gnt) state_d = S_REDIR;
            S_POP_LO: begin
                if (mem.mem_gnt) begin
                    rd_dst_d = RD_LO;
                    state_d  = S_POP_HI;
                end
            end
            S_POP_HI: begin
                if (mem.mem_gnt) begin
                    rd_dst_d = RD_HI;
                    state_d  = reti_q ? S_POP_F : S_CAP;
                end
            end
            S_POP_F: begin
                if (mem.mem_gnt) begin
                    rd_dst_d = RD_FLAGS;
                    state_d  = S_CAP;
                end
            end
            S_CAP:   state_d = S_REDIR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tgt_q     <= '0;
            ret_q     <= '0;
            flags_q   <= '0;
            reti_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_dst_q  <= RD_LO;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            ret_q     <= ret_d;
            flags_q   <= flags_d;
            reti_q    <= reti_d;
            rd_pend_q <= rd_pend_d;
            rd_dst_q  <= rd_dst_d;
        end
    end

    assign pc_load    = (state_q == S_REDIR) && !rst;
    assign pc_next    = pc_load ? tgt_q : '0;
    assign flags_load = pc_load && reti_q;
    assign flags_out  = flags_load ? flags_q : '0;
    assign intr_ack   = accept && intr_go;

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Directed bench for call_ret_sequencer; the interrupt section runs when CALLRET_INTR_EN is defined.
module tb_call_ret_sequencer;
    import cr_pkg::*;

    logic              clk;
    logic              rst;
    logic              call_req, ret_req, reti_req, intr_req;
    logic [PC_W-1:0]   call_target, ret_pc;
    logic [WORD_W-1:0] flags_in;
    logic              stall, pc_load, flags_load, intr_ack, stack_err;
    logic [PC_W-1:0]   pc_next;
    logic [WORD_W-1:0] flags_out;
    logic [SP_W-1:0]   sp;

    int checks = 0;
    int errors = 0;

    call_ret_sequencer_if bus ();

    call_ret_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .reti_req    (reti_req),
        .call_target (call_target),
        .ret_pc      (ret_pc),
        .flags_in    (flags_in),
        .intr_req    (intr_req),
        .mem         (bus),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .flags_load  (flags_load),
        .flags_out   (flags_out),
        .intr_ack    (intr_ack),
        .sp          (sp),
        .stack_err   (stack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Small memory model indexed by the low address bits; read data returns one cycle after grant.
    logic [WORD_W-1:0] mem_arr [0:15];
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_we) mem_arr[bus.mem_addr[3:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_arr[bus.mem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_push(input string tag, input logic [SP_W-1:0] addr, input logic [WORD_W-1:0] data);
        chk({tag, "_req"},   32'(bus.mem_req),   32'd1);
        chk({tag, "_we"},    32'(bus.mem_we),    32'd1);
        chk({tag, "_addr"},  32'(bus.mem_addr),  32'(addr));
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(data));
    endtask

    task automatic chk_pop(input string tag, input logic [SP_W-1:0] addr);
        chk({tag, "_req"},  32'(bus.mem_req),  32'd1);
        chk({tag, "_we"},   32'(bus.mem_we),   32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
    endtask

    initial begin
        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0; reti_req = 1'b0; intr_req = 1'b0;
        call_target = '0; ret_pc = '0; flags_in = '0; bus.mem_gnt = 1'b1;

        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_sp",      32'(sp),         32'h000F_FFFF);
        chk("rst_err",     32'(stack_err),  32'd0);
        chk("rst_stall",   32'(stall),      32'd0);
        chk("rst_pcload",  32'(pc_load),    32'd0);
        chk("rst_pcnext",  32'(pc_next),    32'd0);
        chk("rst_flload",  32'(flags_load), 32'd0);
        chk("rst_memreq",  32'(bus.mem_req), 32'd0);
        chk("rst_intrack", 32'(intr_ack),   32'd0);

        // Reset while in PUSH_LO aborts the CALL
        call_req = 1'b1; ret_pc = 32'hAAAA_BBBB; call_target = 32'h0000_0200;
        #1;
        chk("abort_acc_stall", 32'(stall), 32'd1);
        tick();
        call_req = 1'b0;
        chk_push("abort_hi", 20'hFFFFF, 16'hAAAA);
        tick();
        chk_push("abort_lo", 20'hFFFFE, 16'hBBBB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_sp",     32'(sp),      32'h000F_FFFF);
        chk("abort_stall",  32'(stall),   32'd0);
        chk("abort_pcload", 32'(pc_load), 32'd0);
        tick();
        chk("abort_pcload2", 32'(pc_load), 32'd0);

        // CALL with grant always high
        call_req = 1'b1; ret_pc = 32'h1234_5678; call_target = 32'h0000_0100;
        #1;
        chk("call_acc_stall", 32'(stall), 32'd1);
        tick();
        call_req = 1'b0;
        chk_push("call_hi", 20'hFFFFF, 16'h1234);
        chk("call_c1_pcload", 32'(pc_load), 32'd0);
        tick();
        chk_push("call_lo", 20'hFFFFE, 16'h5678);
        chk("call_c2_pcload", 32'(pc_load), 32'd0);
        tick();
        chk("call_pcload", 32'(pc_load),     32'd1);
        chk("call_pcnext", 32'(pc_next),     32'h0000_0100);
        chk("call_sp",     32'(sp),          32'h000F_FFFD);
        chk("call_flload", 32'(flags_load),  32'd0);
        chk("call_redir_memreq", 32'(bus.mem_req), 32'd0);
        tick();
        chk("call_done_stall",  32'(stall),   32'd0);
        chk("call_done_pcload", 32'(pc_load), 32'd0);

        // RET straight after the CALL
        ret_req = 1'b1;
        #1;
        chk("ret_acc_stall", 32'(stall), 32'd1);
        tick();
        ret_req = 1'b0;
        chk_pop("ret_lo", 20'hFFFFE);
        tick();
        chk_pop("ret_hi", 20'hFFFFF);
        tick();
        chk("ret_cap_pcload", 32'(pc_load), 32'd0);
        tick();
        chk("ret_pcload", 32'(pc_load), 32'd1);
        chk("ret_pcnext", 32'(pc_next), 32'h1234_5678);
        chk("ret_sp",     32'(sp),      32'h000F_FFFF);
        chk("ret_err",    32'(stack_err), 32'd0);
        tick();
        chk("ret_done_stall", 32'(stall), 32'd0);

        // Refill the stack, then RET with the grant withheld for 2 cycles in POP_HI
        call_req = 1'b1; ret_pc = 32'hCAFE_BEEF; call_target = 32'h0000_0300;
        tick();
        call_req = 1'b0;
        repeat (2) tick();
        chk("call2_pcnext", 32'(pc_next), 32'h0000_0300);
        tick();
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk_pop("wret_lo", 20'hFFFFE);
        tick();
        bus.mem_gnt = 1'b0;
        chk_pop("wret_hi_w0", 20'hFFFFF);
        tick();
        chk_pop("wret_hi_w1", 20'hFFFFF);
        chk("wret_w1_sp",     32'(sp),      32'h000F_FFFE);
        chk("wret_w1_pcload", 32'(pc_load), 32'd0);
        tick();
        bus.mem_gnt = 1'b1;
        chk_pop("wret_hi_g", 20'hFFFFF);
        chk("wret_g_pcload", 32'(pc_load), 32'd0);
        tick();
        chk("wret_cap_pcload", 32'(pc_load), 32'd0);
        tick();
        chk("wret_pcload", 32'(pc_load), 32'd1);
        chk("wret_pcnext", 32'(pc_next), 32'hCAFE_BEEF);
        chk("wret_sp",     32'(sp),      32'h000F_FFFF);
        tick();

        // Priority: CALL wins over RET
        call_req = 1'b1; ret_req = 1'b1; ret_pc = 32'h0BAD_F00D;
        tick();
        call_req = 1'b0; ret_req = 1'b0;
        chk("prio_we",    32'(bus.mem_we),    32'd1);
        chk("prio_wdata", 32'(bus.mem_wdata), 32'h0000_0BAD);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // RET from an empty stack underflows and wraps
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk("uf_lo_err", 32'(stack_err), 32'd0);
        tick();
        chk("uf_err",     32'(stack_err), 32'd1);
        chk("uf_sp",      32'(sp),        32'h0000_0000);
        chk_pop("uf_hi", 20'h00001);
        tick();
        chk("uf_cap_sp",  32'(sp),        32'h0000_0001);
        tick();
        chk("uf_redir_pcload", 32'(pc_load), 32'd1);
        tick();
        chk("uf_sticky",  32'(stack_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("uf_rst_err", 32'(stack_err), 32'd0);

`ifdef CALLRET_INTR_EN
        // Interrupt beats CALL; RETI restores flags with the PC
        intr_req = 1'b1; call_req = 1'b1; flags_in = 16'h0005;
        ret_pc = 32'h1111_2222; call_target = 32'h0000_0400;
        #1;
        chk("int_ack",   32'(intr_ack), 32'd1);
        chk("int_stall", 32'(stall),    32'd1);
        tick();
        intr_req = 1'b0; call_req = 1'b0; flags_in = 16'h0000;
        chk("int_ack_pulse", 32'(intr_ack), 32'd0);
        chk_push("int_f", 20'hFFFFF, 16'h0005);
        tick();
        chk_push("int_hi", 20'hFFFFE, 16'h1111);
        tick();
        chk_push("int_lo", 20'hFFFFD, 16'h2222);
        tick();
        chk("int_pcload", 32'(pc_load),    32'd1);
        chk("int_pcnext", 32'(pc_next),    32'h0000_0020);
        chk("int_flload", 32'(flags_load), 32'd0);
        tick();
        reti_req = 1'b1;
        tick();
        reti_req = 1'b0;
        chk_pop("reti_lo", 20'hFFFFD);
        tick();
        chk_pop("reti_hi", 20'hFFFFE);
        tick();
        chk_pop("reti_f", 20'hFFFFF);
        tick();
        chk("reti_cap_pcload", 32'(pc_load), 32'd0);
        tick();
        chk("reti_pcload",   32'(pc_load),    32'd1);
        chk("reti_pcnext",   32'(pc_next),    32'h1111_2222);
        chk("reti_flload",   32'(flags_load), 32'd1);
        chk("reti_flagsout", 32'(flags_out),  32'h0000_0005);
        chk("reti_sp",       32'(sp),         32'h000F_FFFF);
        tick();
`else
        // Without the interrupt feature intr_req is ignored
        intr_req = 1'b1;
        #1;
        chk("noint_ack",   32'(intr_ack), 32'd0);
        chk("noint_stall", 32'(stall),    32'd0);
        tick();
        chk("noint_memreq", 32'(bus.mem_req), 32'd0);
        intr_req = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
